alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Sequencing front-end for the team's 8-bit combinational ALU: accepts 16-bit instructions over a valid/ready handshake, reads operands from a private 4×8 register file, drives the ALU's `op`/`a`/`b` inputs, captures `y`/`zero`, writes the result back, and presents it on a valid/ready result port. It is the initiator side of the ALU interface and sits between the accelerator's command queue and the datapath ALU.

## Interface
- `CNT_W`, default 16: width of the retired-instruction counter.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr_valid` in 1: instruction offered.
- `instr_ready` out 1: block can accept an instruction.
- `instr` in 16: `[15]` imm_sel, `[14:12]` op, `[11:10]` rd, `[9:8]` ra, `[7:0]` imm8 if imm_sel=1, else `[7:6]` rb and `[5:0]` ignored.
- `alu_op` out 3: to ALU `op`; encoding 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 signed SLT.
- `alu_a` out 8: to ALU `a`.
- `alu_b` out 8: to ALU `b`.
- `alu_y` in 8: from ALU `y`.
- `alu_zero` in 1: from ALU `zero`.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer takes result.
- `res_data` out 8: captured `alu_y`.
- `res_zero` out 1: captured `alu_zero`.
- `res_rd` out 2: destination register of the result.
- `dbg_addr` in 2: debug register read address.
- `dbg_data` out 8: combinational `rf[dbg_addr]`.
- `retired_cnt` out CNT_W: count of results handed off.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: `instr_ready`=1. On `instr_valid`: register `alu_op`=op, `alu_a`=rf[ra], `alu_b`= imm_sel ? imm8 : rf[rb], latch rd; go to ISSUE.
- ISSUE: `instr_ready`=0; ALU outputs settle combinationally. At the end of the cycle, rf[rd] ← `alu_y`, `res_data` ← `alu_y`, `res_zero` ← `alu_zero`, `res_rd` ← rd; go to RESP.
- RESP: `res_valid`=1. On `res_ready`: `retired_cnt`+1, go to IDLE. Otherwise hold; `res_*` stay stable.
- `alu_op`/`alu_a`/`alu_b` hold their last issued values until the next accept.
- Register file: all four entries are general-purpose and writable, including rd=0. Operands are read in IDLE, so a back-to-back dependent instruction sees the written value.
- `retired_cnt` wraps from all-ones to 0 modulo 2^CNT_W.
- No `alu_op` value is illegal; the block passes all 8 through unchanged.

## Timing
- Reset (async assert, sync release): state IDLE, `instr_ready`=1 after release, `res_valid`=0, `res_data`/`res_zero`/`res_rd`=0, `alu_op`/`alu_a`/`alu_b`=0, rf all 0x00, `retired_cnt`=0.
- Accept at edge N; `alu_*` valid from N to N+1; rf write and `res_valid`=1 from edge N+1; earliest handoff at edge N+2; next accept at N+3. Peak throughput is 1 instruction per 3 cycles.
- `instr_ready` is a pure function of state (IDLE). No accept while RESP is pending.
- Reset mid-ISSUE or mid-RESP: the in-flight result is discarded, `res_valid` drops immediately, and no rf write or count occurs after assertion.
- `dbg_data` reflects the rf write in the cycle after edge N+1.

## Structure
- Package `alu_issue_pkg`: opcode localparams (`OP_ADD`..`OP_SLT`, shared with the ALU encoding), FSM state enum, `instr` field bit-position constants.
- Sub-module `alu_issue_regfile`: 4×8 registers, one synchronous write port, three combinational read ports (ra, rb, dbg), async active-low reset to zero.
- The ALU is not instantiated inside; the top level wires the ALU to the `alu_*` ports.

## Test plan
Bench wires the team's 8-bit ALU to the `alu_*` ports.
- Reset, then `ADD r1,r0,#0x05` → `res_data`=0x05, `res_zero`=0, `res_rd`=1, `res_valid` at accept+1, `retired_cnt`=1.
- Then `SUB r2,r1,#0x05` (imm) → `res_data`=0x00, `res_zero`=1; `dbg_addr`=2 reads 0x00.
- `ADD r1,r0,#0x80`; `SLT r3,r1,#0x01` → 0x01; then `SLT r3,r0,r1` (reg, 0 < −128) → 0x00, `res_zero`=1.
- `ADD r1,r0,#0x03`; `SLL r2,r1,#0x09` → 0x06 (ALU uses b[2:0]); `XOR r2,r2,r2` (reg) → 0x00.
- Hold `res_ready`=0 for 5 cycles in RESP → `res_valid`, `res_data` stable, `instr_ready`=0, count unchanged; release → count +1, IDLE the next cycle.
- Assert `rst_n`=0 during ISSUE of `ADD r1,r0,#0x7F` → `res_valid`=0 immediately, `dbg_data`(r1)=0x00, `retired_cnt`=0. With CNT_W=4, retire 16 instructions → `retired_cnt` wraps to 0.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: opcodes, FSM states and instruction field positions for alu_issue_ctrl
package alu_issue_pkg;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;
  localparam logic [2:0] OP_SLT = 3'd7;
  localparam int IMM_SEL_BIT = 15;
  localparam int OP_LSB = 12;
  localparam int RD_LSB = 10;
  localparam int RA_LSB = 8;
  localparam int RB_LSB = 6;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;
endpackage

// File: rtl/alu_issue_regfile.sv
// alu_issue_regfile: 4x8 register file, one sync write port, three comb read ports
module alu_issue_regfile (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [1:0] wa,
  input  logic [7:0] wd,
  input  logic [1:0] ra,
  input  logic [1:0] rb,
  input  logic [1:0] dbg_addr,
  output logic [7:0] a_data,
  output logic [7:0] b_data,
  output logic [7:0] dbg_data
);
  logic [7:0] rf [4];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < 4; i++) rf[i] <= '0;
    else if (we) rf[wa] <= wd;
  assign a_data   = rf[ra];
  assign b_data   = rf[rb];
  assign dbg_data = rf[dbg_addr];
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: 3-cycle issue/capture/handoff sequencer driving an external 8-bit ALU
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [15:0]      instr,
  output logic [2:0]       alu_op,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  input  logic [7:0]       alu_y,
  input  logic             alu_zero,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic             res_zero,
  output logic [1:0]       res_rd,
  input  logic [1:0]       dbg_addr,
  output logic [7:0]       dbg_data,
  output logic [CNT_W-1:0] retired_cnt
);
  state_t state, state_nxt;
  logic [1:0] rd;
  logic [7:0] a_data, b_data;
  logic accept, retire;
  assign instr_ready = state == S_IDLE;
  assign res_valid   = state == S_RESP;
  assign accept      = instr_ready && instr_valid;
  assign retire      = res_valid && res_ready;
  always_comb begin
    state_nxt = state;
    state_nxt = state == S_IDLE  ? (instr_valid ? S_ISSUE : S_IDLE) :
                state == S_ISSUE ? S_RESP :
                res_ready        ? S_IDLE : S_RESP;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nxt;
  // operands come from the rf in IDLE, so a result written in ISSUE is visible to the next accept
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      alu_op <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
      rd     <= '0;
    end else if (accept) begin
      alu_op <= instr[OP_LSB +: 3];
      alu_a  <= a_data;
      alu_b  <= instr[IMM_SEL_BIT] ? instr[7:0] : b_data;
      rd     <= instr[RD_LSB +: 2];
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      res_data <= '0;
      res_zero <= 1'b0;
      res_rd   <= '0;
    end else if (state == S_ISSUE) begin
      res_data <= alu_y;
      res_zero <= alu_zero;
      res_rd   <= rd;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) retired_cnt <= '0;
    else if (retire) retired_cnt <= retired_cnt + CNT_W'(1);
  alu_issue_regfile u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (state == S_ISSUE),
    .wa       (rd),
    .wd       (alu_y),
    .ra       (instr[RA_LSB +: 2]),
    .rb       (instr[RB_LSB +: 2]),
    .dbg_addr (dbg_addr),
    .a_data   (a_data),
    .b_data   (b_data),
    .dbg_data (dbg_data)
  );
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench with a behavioural 8-bit ALU on the alu_* ports
module tb_alu_issue_ctrl;
  import alu_issue_pkg::*;
  localparam int CNT_W = 4;
  logic clk = 0, rst_n = 0;
  logic instr_valid = 0, res_ready = 0;
  logic [15:0] instr = '0;
  logic [2:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_y, res_data, dbg_data;
  logic alu_zero, instr_ready, res_valid, res_zero;
  logic [1:0] res_rd, dbg_addr = '0;
  logic [CNT_W-1:0] retired_cnt, cnt_exp = '0;
  int n_cmp = 0, n_bad = 0;

  alu_issue_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
    .alu_zero(alu_zero), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_zero(res_zero), .res_rd(res_rd), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_y = '0;
    case (alu_op)
      OP_ADD:  alu_y = alu_a + alu_b;
      OP_SUB:  alu_y = alu_a - alu_b;
      OP_AND:  alu_y = alu_a & alu_b;
      OP_OR:   alu_y = alu_a | alu_b;
      OP_XOR:  alu_y = alu_a ^ alu_b;
      OP_SLL:  alu_y = alu_a << alu_b[2:0];
      OP_SRL:  alu_y = alu_a >> alu_b[2:0];
      default: alu_y = {7'b0, $signed(alu_a) < $signed(alu_b)};
    endcase
    alu_zero = alu_y == 8'h00;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mk_i(logic [2:0] op, logic [1:0] rd, logic [1:0] ra, logic [7:0] imm);
    return {1'b1, op, rd, ra, imm};
  endfunction

  function automatic logic [15:0] mk_r(logic [2:0] op, logic [1:0] rd, logic [1:0] ra, logic [1:0] rb);
    return {1'b0, op, rd, ra, rb, 6'b0};
  endfunction

  task automatic run(input logic [15:0] ins, input logic [7:0] exp_y, input logic exp_z);
    @(negedge clk);
    chk("ready_idle", instr_ready, 1);
    instr = ins;
    instr_valid = 1;
    dbg_addr = ins[11:10];
    @(posedge clk); #1;
    instr_valid = 0;
    chk("issue_valid", res_valid, 0);
    chk("issue_ready", instr_ready, 0);
    chk("issue_op", alu_op, ins[14:12]);
    @(posedge clk); #1;
    chk("res_valid", res_valid, 1);
    chk("res_data", res_data, exp_y);
    chk("res_zero", res_zero, exp_z);
    chk("res_rd", res_rd, ins[11:10]);
    chk("dbg_rd", dbg_data, exp_y);
    res_ready = 1;
    cnt_exp = cnt_exp + 1'b1;
    @(posedge clk); #1;
    res_ready = 0;
    chk("retired", retired_cnt, cnt_exp);
    chk("back_idle", instr_ready, 1);
  endtask

  task automatic reset_release;
    @(negedge clk);
    rst_n = 1;
    cnt_exp = '0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    reset_release();
    #1;
    chk("rst_ready", instr_ready, 1);
    chk("rst_valid", res_valid, 0);
    chk("rst_data", res_data, 0);
    chk("rst_zero", res_zero, 0);
    chk("rst_rd", res_rd, 0);
    chk("rst_op", alu_op, 0);
    chk("rst_a", alu_a, 0);
    chk("rst_b", alu_b, 0);
    chk("rst_cnt", retired_cnt, 0);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1 chk("rst_rf", dbg_data, 0);
    end
    run(mk_i(OP_ADD, 1, 0, 8'h05), 8'h05, 0);
    run(mk_i(OP_SUB, 2, 1, 8'h05), 8'h00, 1);
    run(mk_i(OP_ADD, 1, 0, 8'h80), 8'h80, 0);
    run(mk_i(OP_SLT, 3, 1, 8'h01), 8'h01, 0);
    run(mk_r(OP_SLT, 3, 0, 1), 8'h00, 1);
    run(mk_i(OP_ADD, 1, 0, 8'h03), 8'h03, 0);
    run(mk_i(OP_SLL, 2, 1, 8'h09), 8'h06, 0);
    run(mk_r(OP_XOR, 2, 2, 2), 8'h00, 1);
    run(mk_i(OP_SRL, 3, 1, 8'h01), 8'h01, 0);
    // result held back by the consumer for five cycles
    @(negedge clk);
    instr = mk_i(OP_ADD, 0, 0, 8'h11);
    instr_valid = 1;
    dbg_addr = 0;
    @(posedge clk); #1;
    instr_valid = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", res_valid, 1);
      chk("stall_data", res_data, 8'h11);
      chk("stall_ready", instr_ready, 0);
      chk("stall_cnt", retired_cnt, cnt_exp);
      chk("stall_b", alu_b, 8'h11);
      @(posedge clk); #1;
    end
    chk("stall_rf", dbg_data, 8'h11);
    res_ready = 1;
    cnt_exp = cnt_exp + 1'b1;
    @(posedge clk); #1;
    res_ready = 0;
    chk("stall_release_cnt", retired_cnt, cnt_exp);
    chk("stall_release_idle", instr_ready, 1);
    chk("stall_release_valid", res_valid, 0);
    // reset while the instruction is in ISSUE
    @(negedge clk);
    instr = mk_i(OP_ADD, 1, 0, 8'h7F);
    instr_valid = 1;
    dbg_addr = 1;
    @(posedge clk); #1;
    instr_valid = 0;
    rst_n = 0;
    #1;
    chk("rst_issue_valid", res_valid, 0);
    chk("rst_issue_cnt", retired_cnt, 0);
    @(posedge clk); #1;
    chk("rst_issue_rf", dbg_data, 0);
    chk("rst_issue_valid2", res_valid, 0);
    reset_release();
    // reset while the result is pending in RESP
    @(negedge clk);
    instr = mk_i(OP_ADD, 2, 0, 8'h42);
    instr_valid = 1;
    dbg_addr = 2;
    @(posedge clk); #1;
    instr_valid = 0;
    @(posedge clk); #1;
    chk("pre_rst_valid", res_valid, 1);
    res_ready = 1;
    rst_n = 0;
    #1;
    chk("rst_resp_valid", res_valid, 0);
    chk("rst_resp_data", res_data, 0);
    chk("rst_resp_rf", dbg_data, 0);
    @(posedge clk); #1;
    res_ready = 0;
    chk("rst_resp_cnt", retired_cnt, 0);
    reset_release();
    for (int i = 0; i < 16; i++)
      run(mk_i(OP_ADD, 0, 0, 8'h01), 8'(i + 1), 0);
    chk("cnt_wrap", retired_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
